// File: rtl/seq_divider8.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// Each RUN cycle does one ripple trial subtraction and produces one quotient bit, MSB first.
module seq_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic             c;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             accept;

  // Handshake: start is taken on a rising edge only when busy=0 (IDLE or DONE);
  // done is a one-cycle pulse marking results valid, and results hold until the next accept.
  assign accept    = start && (state != RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

  // Ripple trial subtraction a + ~b + 1; the final carry set means no borrow.
  always_comb begin
    shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    sub_b   = ~{1'b0, dsr_q};
    trial   = '0;
    c       = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      trial[i] = shifted[i] ^ sub_b[i] ^ c;
      c        = (shifted[i] & sub_b[i]) | (c & (shifted[i] ^ sub_b[i]));
    end
    no_borrow = c;
    rem_next  = no_borrow ? trial : shifted;
    quo_next  = {quo_q[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            dvd_q <= dividend;
            dsr_q <= divisor;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            if (divisor == '0) begin
              // Divide by zero finishes on the accepting edge without iterating.
              state       <= DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= RUN;
              quotient    <= '0;
              remainder   <= '0;
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state     <= DONE;
            quotient  <= quo_next;
            remainder <= rem_next[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider8.sv
// Directed and randomized checks of seq_divider8 against plain / and % arithmetic.
module tb_seq_divider8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic [1:0] dbg_state;

  int vectors;
  int miscompares;

  seq_divider8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic from the operation rules.
  function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [7:0] b);
    return (b == 8'd0) ? 8'hFF : a / b;
  endfunction

  function automatic logic [7:0] ref_r(input logic [7:0] a, input logic [7:0] b);
    return (b == 8'd0) ? a : a % b;
  endfunction

  // Drive one request on a falling edge and follow it to done. Returns in the
  // done cycle (#1 after the completing edge). If poke_at >= 0, a 9/3 start is
  // pulsed during that iteration to confirm it is ignored while busy.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int poke_at);
    int n;
    int busy_n;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    if (b != 8'd0) begin
      check("cleared_quotient", quotient, 0);
      check("cleared_remainder", remainder, 0);
    end
    n      = 0;
    busy_n = 0;
    while (!done && n < 20) begin
      if (busy) busy_n++;
      if (n == poke_at) begin
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("latency", n, (b == 8'd0) ? 0 : 8);
    check("busy_cycles", busy_n, (b == 8'd0) ? 0 : 8);
    check("quotient", quotient, ref_q(a, b));
    check("remainder", remainder, ref_r(a, b));
    check("div_by_zero", div_by_zero, (b == 8'd0) ? 1 : 0);
  endtask

  // One idle cycle after done: pulse ends, results hold.
  task automatic idle_check(input logic [7:0] a, input logic [7:0] b);
    @(posedge clk);
    #1;
    check("done_pulse_end", done, 0);
    check("idle_busy", busy, 0);
    check("hold_quotient", quotient, ref_q(a, b));
    check("hold_remainder", remainder, ref_r(a, b));
    check("hold_dbz", div_by_zero, (b == 8'd0) ? 1 : 0);
  endtask

  initial begin
    int done_seen;
    logic [7:0] ra;
    logic [7:0] rb;
    vectors     = 0;
    miscompares = 0;
    start       = 1'b0;
    dividend    = 8'd0;
    divisor     = 8'd0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic and boundary divides
    run_op(8'd100, 8'd7, -1);   idle_check(8'd100, 8'd7);
    run_op(8'd255, 8'd128, -1); idle_check(8'd255, 8'd128);
    run_op(8'd255, 8'd1, -1);   idle_check(8'd255, 8'd1);
    run_op(8'd7, 8'd9, -1);     idle_check(8'd7, 8'd9);
    run_op(8'd5, 8'd0, -1);     idle_check(8'd5, 8'd0);
    run_op(8'd200, 8'd200, -1); idle_check(8'd200, 8'd200);

    // Start while busy is ignored, then back-to-back from the done cycle
    run_op(8'd100, 8'd7, 4);
    run_op(8'd9, 8'd3, -1);
    idle_check(8'd9, 8'd3);

    // Back-to-back divide-by-zero then normal
    run_op(8'd77, 8'd0, -1);
    run_op(8'd250, 8'd16, -1);
    idle_check(8'd250, 8'd16);

    // Reset in the middle of RUN aborts with no done pulse
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd13;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    done_seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) done_seen = 1;
    end
    check("abort_no_done", done_seen, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd200, 8'd13, -1);
    idle_check(8'd200, 8'd13);

    // Randomized operands, roughly one in eight with a zero divisor
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run_op(ra, rb, -1);
      if ($urandom_range(0, 1) == 1) idle_check(ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
